// File: rtl/divider_if.sv
// Operand/result bundle shared by the EX-stage divider and its requester.
interface divider_if;
  logic        ce;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        stall;

  modport master (output ce, funct3, a, b, input result, stall);
  modport slave  (input ce, funct3, a, b, output result, stall);
endinterface

// File: rtl/divider.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle; 35-cycle op.
// DIVIDER_EARLY_OUT_EN: b=0 and signed-overflow ops skip CALC (3-cycle op).
module divider (
  input  logic     clk,
  input  logic     reset,
  divider_if.slave dif
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic [31:0] result_q, result_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        sel_rem_q, sel_rem_d;
  logic        spec_q, spec_d;

  logic        start, is_signed, a_neg, b_neg, b_zero, ovf;
  logic [32:0] shifted, diff;

  assign start     = (state_q == IDLE) && dif.ce && dif.funct3[2];
  assign is_signed = ~dif.funct3[0];
  assign a_neg     = is_signed & dif.a[31];
  assign b_neg     = is_signed & dif.b[31];
  assign b_zero    = (dif.b == 32'd0);
  assign ovf       = is_signed && (dif.a == 32'h8000_0000) && (dif.b == 32'hFFFF_FFFF);

  // Partial remainder is always below the divisor, so 33 bits hold the shifted value.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    sel_rem_d  = sel_rem_q;
    spec_d     = spec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d      = a_neg ? (32'd0 - dif.a) : dif.a;
          dvs_d      = b_neg ? (32'd0 - dif.b) : dif.b;
          rem_d      = 32'd0;
          cnt_d      = 6'd0;
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          sel_rem_d  = dif.funct3[1];
          spec_d     = b_zero | ovf;
          spec_val_d = b_zero ? (dif.funct3[1] ? dif.a : 32'hFFFF_FFFF)
                              : (dif.funct3[1] ? 32'd0 : 32'h8000_0000);
`ifdef DIVIDER_EARLY_OUT_EN
          state_d    = (b_zero | ovf) ? FIX : CALC;
`else
          state_d    = CALC;
`endif
        end
      end
      CALC: begin
        quo_d = {quo_q[30:0], ~diff[32]};
        rem_d = diff[32] ? shifted[31:0] : diff[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (spec_q)
          result_d = spec_val_q;
        else if (sel_rem_q)
          result_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        else
          result_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      spec_val_q <= 32'd0;
      result_q   <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      sel_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      sel_rem_q  <= sel_rem_d;
      spec_q     <= spec_d;
    end
  end

  assign dif.stall  = ~reset & (start | (state_q == CALC) | (state_q == FIX));
  assign dif.result = result_q;
endmodule

// File: tb/tb_divider.sv
// Bench for divider: cycle-level reference model checked every cycle plus literal results.
module tb_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  divider_if dif ();
  divider dut (.clk(clk), .reset(reset), .dif(dif));

`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V divide semantics straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return sa / sb;
      3'b101: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'b110: if (b == 0) return a; else if (ovf) return 32'd0; else return sa % sb;
      3'b111: if (b == 0) return a; else return a % b;
      default: return 32'd0;
    endcase
  endfunction

  int          phase    = -1;
  int          lat      = 0;
  logic [31:0] exp_res  = 32'd0;
  logic [31:0] last_res = 32'd0;

  // phase = cycle index within the current op (0 = accept cycle), -1 when idle.
  always @(negedge clk) begin
    if (reset) begin
      phase    = -1;
      last_res = 32'd0;
    end else if (phase < 0 && dif.ce && dif.funct3[2]) begin
      phase   = 0;
      exp_res = ref_result(dif.funct3, dif.a, dif.b);
      lat     = (EARLY && is_special(dif.funct3, dif.a, dif.b)) ? 3 : 35;
    end
    check("stall", {31'd0, dif.stall}, {31'd0, (phase >= 0) && (phase < lat - 1)});
    check("result", dif.result, (phase >= 0 && phase == lat - 1) ? exp_res : last_res);
    if (phase >= 0) begin
      phase++;
      if (phase == lat) begin
        last_res = exp_res;
        phase    = -1;
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    n = (EARLY && is_special(f3, a, b)) ? 3 : 35;
    @(posedge clk); #1;
    dif.ce = 1'b1; dif.funct3 = f3; dif.a = a; dif.b = b;
    @(posedge clk); #1;
    dif.ce = 1'b0; dif.funct3 = 3'b000; dif.a = ~a; dif.b = b + 32'd1;
    repeat (n - 2) @(posedge clk);
    #1;
    check(name, dif.result, exp);
  endtask

  initial begin
    dif.ce = 1'b0; dif.funct3 = 3'b000; dif.a = 32'd0; dif.b = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    run_op("div_20_m3",    3'b100, 32'd20,          32'hFFFF_FFFD, 32'hFFFF_FFFA);
    run_op("rem_20_m3",    3'b110, 32'd20,          32'hFFFF_FFFD, 32'h0000_0002);
    run_op("rem_m20_3",    3'b110, 32'hFFFF_FFEC,   32'd3,         32'hFFFF_FFFE);
    run_op("divu_max_2",   3'b101, 32'hFFFF_FFFF,   32'd2,         32'h7FFF_FFFF);
    run_op("remu_max_2",   3'b111, 32'hFFFF_FFFF,   32'd2,         32'h0000_0001);
    run_op("div_7_0",      3'b100, 32'd7,           32'd0,         32'hFFFF_FFFF);
    run_op("remu_7_0",     3'b111, 32'd7,           32'd0,         32'h0000_0007);
    run_op("rem_ovf",      3'b110, 32'h8000_0000,   32'hFFFF_FFFF, 32'h0000_0000);
    run_op("divu_nospec",  3'b101, 32'h8000_0000,   32'hFFFF_FFFF, 32'h0000_0000);
    run_op("div_ovf",      3'b100, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000);

    // Reset at cycle 10 of an op, with a start request held during reset.
    @(posedge clk); #1;
    dif.ce = 1'b1; dif.funct3 = 3'b100; dif.a = 32'd1000; dif.b = 32'd3;
    @(posedge clk); #1;
    dif.ce = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_stall",  {31'd0, dif.stall}, 32'd0);
    check("rst_result", dif.result, 32'd0);
    dif.ce = 1'b1; dif.funct3 = 3'b100; dif.a = 32'd50; dif.b = 32'd5;
    @(posedge clk); #1;
    check("rst_ce_stall", {31'd0, dif.stall}, 32'd0);
    @(posedge clk); #1;
    dif.ce = 1'b0; reset = 1'b0;
    @(posedge clk);

    run_op("divu_100_7",   3'b101, 32'd100,         32'd7,         32'h0000_000E);

    // Multiply-class requests must be ignored.
    @(posedge clk); #1;
    dif.ce = 1'b1; dif.funct3 = 3'b000; dif.a = 32'd9; dif.b = 32'd3;
    repeat (3) @(posedge clk);
    #1 dif.funct3 = 3'b011;
    repeat (2) @(posedge clk);
    #1 dif.ce = 1'b0;

    run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
